// File: rtl/rf_pkg.sv
// rf_pkg: shared definitions for the vector register file.
//   - Default geometry (REGISTERS, LANES, WIDTH) used as parameter defaults.
//   - Clear-sweep FSM state type.
package rf_pkg;

    localparam int unsigned RF_REGISTERS = 32;
    localparam int unsigned RF_LANES     = 4;
    localparam int unsigned RF_WIDTH     = 16;

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        CLEAR = 1'b1
    } rf_state_e;

endpackage

// File: rtl/rf_lane_bank.sv
// rf_lane_bank: one lane of the vector register file, REGISTERS x WIDTH.
//   i_clk, i_rst        clock, asynchronous active-high reset (zeroes every entry)
//   i_we, i_waddr,
//   i_wdata             synchronous write port
//   i_clr, i_clr_addr   synchronous zeroing of one entry (clear sweep)
//   i_raddr1/2,
//   o_rdata1/2          two combinational read ports (raw stored data)
module rf_lane_bank
    import rf_pkg::*;
#(
    parameter int unsigned REGISTERS = RF_REGISTERS,
    parameter int unsigned WIDTH     = RF_WIDTH
) (
    input  logic                         i_clk,
    input  logic                         i_rst,
    input  logic                         i_we,
    input  logic [$clog2(REGISTERS)-1:0] i_waddr,
    input  logic [WIDTH-1:0]             i_wdata,
    input  logic                         i_clr,
    input  logic [$clog2(REGISTERS)-1:0] i_clr_addr,
    input  logic [$clog2(REGISTERS)-1:0] i_raddr1,
    input  logic [$clog2(REGISTERS)-1:0] i_raddr2,
    output logic [WIDTH-1:0]             o_rdata1,
    output logic [WIDTH-1:0]             o_rdata2
);

    logic [WIDTH-1:0] r_mem [REGISTERS];

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            for (int i = 0; i < REGISTERS; i++) begin
                r_mem[i] <= '0;
            end
        end else begin
            if (i_we) begin
                r_mem[i_waddr] <= i_wdata;
            end
            // Placed after the write so a clear always wins on a collision.
            if (i_clr) begin
                r_mem[i_clr_addr] <= '0;
            end
        end
    end

    assign o_rdata1 = r_mem[i_raddr1];
    assign o_rdata2 = r_mem[i_raddr2];

endmodule

// File: rtl/register_file_vectorial.sv
// register_file_vectorial: REGISTERS x LANES x WIDTH vector register file with
// per-lane write mask, write-through bypass, pending-bit scoreboard and a
// sequential clear sweep.
//   clk, rst            clock, asynchronous active-high reset
//   we3, a3, wd3, wmask masked write port (ignored while clr_busy)
//   a1, a2 -> rd1, rd2  combinational reads; register 0 reads zero
//   sb_set, sb_addr     mark a register pending
//   pend1, pend2        pending bits of a1/a2
//   clr_req, clr_busy   start / status of the whole-file clear sweep
module register_file_vectorial
    import rf_pkg::*;
#(
    parameter int unsigned REGISTERS = RF_REGISTERS,
    parameter int unsigned LANES     = RF_LANES,
    parameter int unsigned WIDTH     = RF_WIDTH
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         we3,
    input  logic [$clog2(REGISTERS)-1:0] a1,
    input  logic [$clog2(REGISTERS)-1:0] a2,
    input  logic [$clog2(REGISTERS)-1:0] a3,
    input  logic [LANES*WIDTH-1:0]       wd3,
    input  logic [LANES-1:0]             wmask,
    output logic [LANES*WIDTH-1:0]       rd1,
    output logic [LANES*WIDTH-1:0]       rd2,
    input  logic                         sb_set,
    input  logic [$clog2(REGISTERS)-1:0] sb_addr,
    output logic                         pend1,
    output logic                         pend2,
    input  logic                         clr_req,
    output logic                         clr_busy
);

    localparam int unsigned AW = $clog2(REGISTERS);
    localparam logic [AW-1:0] LAST = AW'(REGISTERS - 1);

    rf_state_e          r_state;
    logic [AW-1:0]      r_cnt;
    logic [REGISTERS-1:0] r_pending;

    logic               w_wr_act;
    logic               w_sb_act;
    logic               w_sweep;
    logic [WIDTH-1:0]   w_lane_rd1 [LANES];
    logic [WIDTH-1:0]   w_lane_rd2 [LANES];

    assign w_sweep  = (r_state == CLEAR);
    assign clr_busy = w_sweep;
    // Register 0 is hard-wired to zero, so writes and sets on it are dropped here.
    assign w_wr_act = we3 && !w_sweep && (a3 != '0);
    assign w_sb_act = sb_set && !w_sweep && (sb_addr != '0);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= IDLE;
            r_cnt     <= '0;
            r_pending <= '0;
        end else begin
            unique case (r_state)
                IDLE: begin
                    if (clr_req) begin
                        // Entry 0 is never written, so the sweep starts at 1.
                        r_state   <= CLEAR;
                        r_cnt     <= AW'(1);
                        r_pending <= '0;
                    end else begin
                        if (w_wr_act) begin
                            r_pending[a3] <= 1'b0;
                        end
                        // Later assignment: a same-cycle set beats the write's clear.
                        if (w_sb_act) begin
                            r_pending[sb_addr] <= 1'b1;
                        end
                    end
                end
                CLEAR: begin
                    if (r_cnt == LAST) begin
                        r_state <= IDLE;
                        r_cnt   <= '0;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    for (genvar g = 0; g < LANES; g++) begin : g_lane
        rf_lane_bank #(
            .REGISTERS (REGISTERS),
            .WIDTH     (WIDTH)
        ) u_bank (
            .i_clk      (clk),
            .i_rst      (rst),
            .i_we       (w_wr_act && wmask[g]),
            .i_waddr    (a3),
            .i_wdata    (wd3[g*WIDTH +: WIDTH]),
            .i_clr      (w_sweep),
            .i_clr_addr (r_cnt),
            .i_raddr1   (a1),
            .i_raddr2   (a2),
            .o_rdata1   (w_lane_rd1[g]),
            .o_rdata2   (w_lane_rd2[g])
        );
    end

    // Read mux: zero during sweep and for r0, otherwise per-lane bypass of masked write data.
    always_comb begin
        rd1 = '0;
        rd2 = '0;
        if (!w_sweep) begin
            for (int i = 0; i < LANES; i++) begin
                if (a1 != '0) begin
                    rd1[i*WIDTH +: WIDTH] = (w_wr_act && (a3 == a1) && wmask[i])
                                          ? wd3[i*WIDTH +: WIDTH] : w_lane_rd1[i];
                end
                if (a2 != '0) begin
                    rd2[i*WIDTH +: WIDTH] = (w_wr_act && (a3 == a2) && wmask[i])
                                          ? wd3[i*WIDTH +: WIDTH] : w_lane_rd2[i];
                end
            end
        end
    end

    assign pend1 = r_pending[a1];
    assign pend2 = r_pending[a2];

endmodule

// File: tb/tb_register_file_vectorial.sv
// Self-checking bench for register_file_vectorial: behavioural model compared
// every cycle, random stimulus, plus hand-computed scenario checks.
module tb_register_file_vectorial;

    localparam int R  = 32;
    localparam int L  = 4;
    localparam int W  = 16;
    localparam int AW = 5;
    localparam int DW = L * W;

    logic          clk = 1'b0;
    logic          rst;
    logic          we3;
    logic [AW-1:0] a1;
    logic [AW-1:0] a2;
    logic [AW-1:0] a3;
    logic [DW-1:0] wd3;
    logic [L-1:0]  wmask;
    logic [DW-1:0] rd1;
    logic [DW-1:0] rd2;
    logic          sb_set;
    logic [AW-1:0] sb_addr;
    logic          pend1;
    logic          pend2;
    logic          clr_req;
    logic          clr_busy;

    always #5 clk = ~clk;

    register_file_vectorial #(
        .REGISTERS (R),
        .LANES     (L),
        .WIDTH     (W)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .we3      (we3),
        .a1       (a1),
        .a2       (a2),
        .a3       (a3),
        .wd3      (wd3),
        .wmask    (wmask),
        .rd1      (rd1),
        .rd2      (rd2),
        .sb_set   (sb_set),
        .sb_addr  (sb_addr),
        .pend1    (pend1),
        .pend2    (pend2),
        .clr_req  (clr_req),
        .clr_busy (clr_busy)
    );

    int n_checks = 0;
    int n_pass   = 0;

    // Model: plain array of lane values, pending flags, and cycles of sweep left.
    logic [W-1:0] m_mem [R][L];
    bit           m_pend [R];
    int           m_busy_left;

    task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        n_checks++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [DW-1:0] exp_rd(input logic [AW-1:0] a);
        logic [DW-1:0] v;
        v = '0;
        if (m_busy_left > 0 || a == 0) return v;
        for (int l = 0; l < L; l++) begin
            v[l*W +: W] = (we3 && a3 == a && wmask[l]) ? wd3[l*W +: W] : m_mem[a][l];
        end
        return v;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < R; i++) begin
            m_pend[i] = 1'b0;
            for (int l = 0; l < L; l++) m_mem[i][l] = '0;
        end
        m_busy_left = 0;
    endtask

    // Model update. A sweep is unobservable until it ends (reads are zero, writes
    // dropped), so the model simply wipes everything when a clear is accepted.
    initial begin
        model_reset();
        forever begin
            @(posedge clk or posedge rst);
            if (rst) begin
                model_reset();
            end else if (m_busy_left > 0) begin
                m_busy_left--;
            end else begin
                if (we3 && a3 != 0) begin
                    for (int l = 0; l < L; l++) begin
                        if (wmask[l]) m_mem[a3][l] = wd3[l*W +: W];
                    end
                    m_pend[a3] = 1'b0;
                end
                if (sb_set && sb_addr != 0) m_pend[sb_addr] = 1'b1;
                if (clr_req) begin
                    for (int i = 0; i < R; i++) begin
                        m_pend[i] = 1'b0;
                        for (int l = 0; l < L; l++) m_mem[i][l] = '0;
                    end
                    m_busy_left = R - 1;
                end
            end
        end
    end

    // Per-cycle compare against the model, away from the active edge.
    initial begin
        forever begin
            @(negedge clk);
            if (rst === 1'b0) begin
                check("rd1", rd1, exp_rd(a1));
                check("rd2", rd2, exp_rd(a2));
                check("pend1", DW'(pend1), DW'(m_pend[a1]));
                check("pend2", DW'(pend2), DW'(m_pend[a2]));
                check("clr_busy", DW'(clr_busy), DW'(m_busy_left > 0));
            end
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        we3 = 0; sb_set = 0; clr_req = 0; wmask = '0; wd3 = '0;
        a3 = '0; sb_addr = '0;
    endtask

    int busy_cnt;

    initial begin
        rst = 1; a1 = '0; a2 = '0;
        idle_inputs();
        repeat (2) @(posedge clk);
        #1;
        a1 = 5; a2 = 31;
        #1;
        check("reset_rd1", rd1, '0);
        check("reset_busy", DW'(clr_busy), '0);
        check("reset_pend1", DW'(pend1), '0);
        rst = 0;

        // Full-mask write then read back.
        cyc();
        we3 = 1; a3 = 5; wd3 = 64'h4444_3333_2222_1111; wmask = 4'b1111;
        cyc();
        we3 = 0; a1 = 5;
        #1 check("wr_full_rd1", rd1, 64'h4444_3333_2222_1111);

        // Masked write with same-cycle bypass.
        we3 = 1; a3 = 5; wd3 = 64'hFFFF_FFFF_FFFF_FFFF; wmask = 4'b0101;
        #1 check("bypass_rd1", rd1, 64'h4444_FFFF_2222_FFFF);
        cyc();
        we3 = 0;
        #1 check("masked_store", rd1, 64'h4444_FFFF_2222_FFFF);

        // Register 0 is immutable and never pending.
        we3 = 1; a3 = 0; wd3 = 64'hABCD_ABCD_ABCD_ABCD; wmask = 4'b1011; a2 = 0;
        #1 check("r0_bypass_rd2", rd2, '0);
        cyc();
        we3 = 0; sb_set = 1; sb_addr = 0;
        cyc();
        sb_set = 0; a1 = 0;
        #1 check("r0_pend1", DW'(pend1), '0);
        check("r0_rd2", rd2, '0);

        // Scoreboard set / clear by mask-less write / set wins.
        sb_set = 1; sb_addr = 7;
        cyc();
        sb_set = 0; a1 = 7;
        #1 check("sb_set_pend1", DW'(pend1), 64'd1);
        we3 = 1; a3 = 7; wmask = 4'b0000; wd3 = 64'h5555_6666_7777_8888;
        cyc();
        we3 = 0;
        #1 check("wr_clears_pend", DW'(pend1), '0);
        check("mask0_no_data", rd1, '0);
        sb_set = 1; sb_addr = 7; we3 = 1; a3 = 7; wmask = 4'b0001; wd3 = 64'h1234;
        cyc();
        sb_set = 0; we3 = 0;
        #1 check("set_wins", DW'(pend1), 64'd1);
        check("r7_lane0", rd1, 64'h0000_0000_0000_1234);

        // Random traffic, checked by the per-cycle compare.
        repeat (2000) begin
            cyc();
            we3     = 1'($urandom % 2);
            a3      = AW'($urandom_range(0, R - 1));
            a1      = AW'($urandom_range(0, R - 1));
            a2      = AW'($urandom_range(0, R - 1));
            if ($urandom % 4 == 0) a1 = a3;
            if ($urandom % 4 == 0) a2 = a3;
            wd3     = {$urandom, $urandom};
            wmask   = L'($urandom);
            sb_set  = ($urandom % 4 == 0);
            sb_addr = ($urandom % 3 == 0) ? a3 : AW'($urandom_range(0, R - 1));
            clr_req = ($urandom % 64 == 0);
        end
        cyc();
        idle_inputs();
        repeat (R + 2) cyc();

        // Fill every register, mark them pending, then sweep.
        for (int i = 1; i < R; i++) begin
            we3 = 1; a3 = AW'(i); wmask = 4'b1111;
            wd3 = 64'h8000_0000_0000_0000 | 64'(i);
            sb_set = 1; sb_addr = AW'(i);
            cyc();
        end
        a1 = 3;
        we3 = 1; a3 = 3; wd3 = 64'hDEAD_BEEF_CAFE_F00D; wmask = 4'b1111;
        sb_set = 0; clr_req = 1;
        cyc();
        clr_req = 0; we3 = 0;
        busy_cnt = 0;
        for (int k = 0; k < 100; k++) begin
            if (!clr_busy) break;
            busy_cnt++;
            we3 = 1; a3 = AW'(k % (R - 1) + 1); wmask = 4'b1111; wd3 = '1;
            sb_set = 1; sb_addr = 9; clr_req = (k == 5); a1 = a3;
            #1;
            if (k == 3) check("busy_rd1_zero", rd1, '0);
            cyc();
        end
        idle_inputs();
        check("sweep_len", DW'(busy_cnt), 64'd31);
        for (int a = 0; a < R; a++) begin
            a1 = AW'(a); a2 = AW'(R - 1 - a);
            #1;
            check("post_clear_rd1", rd1, '0);
            check("post_clear_pend1", DW'(pend1), '0);
        end

        // Reset in the middle of a sweep.
        cyc();
        for (int i = 1; i < 9; i++) begin
            we3 = 1; a3 = AW'(i); wmask = 4'b1111; wd3 = {4{16'(i)}};
            cyc();
        end
        we3 = 0; clr_req = 1;
        cyc();
        clr_req = 0;
        repeat (10) cyc();
        #1 rst = 1; a1 = 2;
        #1 check("rst_busy_now", DW'(clr_busy), '0);
        check("rst_rd1_now", rd1, '0);
        cyc();
        rst = 0;
        #1 check("after_rst_idle", DW'(clr_busy), '0);
        for (int a = 0; a < R; a++) begin
            a1 = AW'(a);
            #1 check("after_rst_rd1", rd1, '0);
        end
        we3 = 1; a3 = 4; wmask = 4'b1111; wd3 = 64'h0102_0304_0506_0708;
        cyc();
        we3 = 0; a1 = 4;
        #1 check("after_rst_write", rd1, 64'h0102_0304_0506_0708);
        cyc();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
